memory_port_arbiter: RTL and testbench
======================================

# memory_port_arbiter

Shares the single-ported unified memory bus between the fetch stage (instruction reads) and the memory stage (loads/stores), one transaction outstanding at a time. It arbitrates the two requesters and sequences each transaction through a request/accept/response handshake. It generates byte enables and lane-aligned write data from `memoryWidth`, and routes the response back to the owner. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants with fetch waiting before fetch is forced to win; must be ≥1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `fetchRequest`  in  1  fetch wants a word read; held until `fetchGrant`.
- `fetchAddress`  in  32  fetch byte address; bits [1:0] ignored.
- `fetchFlush`  in  1  discard any in-flight fetch response.
- `fetchGrant`  out  1  one-cycle pulse: fetch request captured.
- `fetchResponseValid`  out  1  one-cycle pulse: `fetchResponseData` valid.
- `fetchResponseData`  out  32  instruction word.
- `memoryRequest`  in  1  memory stage wants an access; held until `memoryGrant`.
- `memoryAddress`  in  32  data byte address.
- `memoryWriteEnable`  in  1  1 = store, 0 = load.
- `memoryWidth`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `memoryWriteData`  in  32  store data, right-aligned.
- `memoryGrant`  out  1  one-cycle pulse: data request captured.
- `memoryResponseValid`  out  1  one-cycle pulse: load data or store completion.
- `memoryResponseData`  out  32  raw bus word; the memory stage extracts and extends it.
- `busRequestValid`  out  1  transaction presented.
- `busRequestReady`  in  1  bus accepts when high with valid.
- `busAddress`  out  32  captured address with [1:0] forced to 0.
- `busWriteEnable`  out  1  store.
- `busByteEnable`  out  4  active lanes.
- `busWriteData`  out  32  lane-shifted store data.
- `busResponseValid`  in  1  one response per accepted request, reads and writes.
- `busResponseData`  in  32  read data.

## Operation
- FSM states: IDLE, REQUEST, WAIT.
- IDLE:
  - If any request is asserted, choose an owner and capture address, write enable, byte enables and data.
  - Pulse the owner's grant and go to REQUEST.
  - Arbitration: data wins, except that fetch wins when both request and `starveCount == STARVE_LIMIT`.
- REQUEST: hold `busRequestValid`=1 with stable fields until `busRequestReady`, then go to WAIT.
- WAIT:
  - On `busResponseValid`, drive the owner's response valid and data combinationally from the bus, then go to IDLE.
  - Exception: for a fetch owner with `dropFetch`=1, suppress `fetchResponseValid`, clear `dropFetch`, and go to IDLE.
- `starveCount`:
  - Increments (saturating at `STARVE_LIMIT`) on a data grant while `fetchRequest`=1.
  - Clears on a fetch grant, or on a data grant while `fetchRequest`=0.
- `dropFetch`:
  - Set when `fetchFlush`=1 while the owner is fetch in REQUEST or WAIT.
  - `fetchFlush` in the same cycle as the fetch response also suppresses `fetchResponseValid`.
  - `fetchFlush` in IDLE has no effect; the requester drops `fetchRequest` itself.
- Byte enables and write data for a data access, with a = address[1:0]:
  - Byte: enable 0001<<a, data = byte replicated ×4.
  - Half: enable 0011<<{a[1],0}, data = half replicated ×2.
  - Word or 11: enable 1111, data unchanged.
  - Misalignment is not checked.
- Fetch access: enable 1111, write enable 0, write data 0.
- `busResponseValid` in IDLE or REQUEST is ignored.
- `busRequestReady` is ignored when `busRequestValid`=0.

## Timing
- Reset (asynchronous):
  - State → IDLE, `starveCount`=0, `dropFetch`=0.
  - All outputs are 0: grants, response valids, `busRequestValid`, `busAddress`, `busWriteEnable`, `busByteEnable`, `busWriteData`.
  - Response data outputs are 0 while their valid is 0.
- Reset mid-transaction abandons it; the bus is reset on the same `reset`.
- Grant and `busRequestValid` are registered:
  - A request seen in IDLE at cycle 0 gives the grant pulse and `busRequestValid`=1 in cycle 1.
  - With `busRequestReady`=1 in cycle 1 and the response in cycle 2, response valid is high in cycle 2.
  - IDLE is re-entered in cycle 3; minimum issue interval is 3 cycles.
- Requester inputs are sampled only in IDLE; changes after grant are ignored.

## Test plan
- Lone fetch at 0x80000000, bus ready immediately, response 0x00000013 next cycle:
  - `fetchGrant` in cycle 1, `busAddress`=0x80000000, `busByteEnable`=1111.
  - `fetchResponseValid` with 0x00000013 in cycle 2.
- Store byte 0xAB to 0x1003:
  - `busByteEnable`=1000, `busWriteData`=0xABABABAB, `busWriteEnable`=1.
  - `memoryResponseValid` pulses on the bus response.
- Half store 0x1234 to 0x1002:
  - `busByteEnable`=1100, `busWriteData`=0x12341234, `busAddress`=0x1000.
- Both requesting continuously, `STARVE_LIMIT`=4:
  - Grant order is D,D,D,D,F,D,D,D,D,F.
  - `starveCount` returns to 0 after each fetch grant.
- Fetch granted, `busRequestReady` held 0 for 5 cycles, `fetchFlush` pulsed in cycle 3:
  - Bus fields stay stable throughout.
  - Response arrives and `fetchResponseValid` stays 0.
  - Next grant follows normally.
- `reset` asserted in WAIT:
  - All outputs go to 0 immediately.
  - A later stray `busResponseValid` produces no response pulse.
  - The next request is granted one cycle after it is presented.

Source files
------------

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// memory_port_arbiter: shares one memory bus between fetch and data requesters
// Revision: 1.0
// ============================================================================
module memory_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  input  logic        fetchFlush,
  output logic        fetchGrant,
  output logic        fetchResponseValid,
  output logic [31:0] fetchResponseData,
  input  logic        memoryRequest,
  input  logic [31:0] memoryAddress,
  input  logic        memoryWriteEnable,
  input  logic [1:0]  memoryWidth,
  input  logic [31:0] memoryWriteData,
  output logic        memoryGrant,
  output logic        memoryResponseValid,
  output logic [31:0] memoryResponseData,
  output logic        busRequestValid,
  input  logic        busRequestReady,
  output logic [31:0] busAddress,
  output logic        busWriteEnable,
  output logic [3:0]  busByteEnable,
  output logic [31:0] busWriteData,
  input  logic        busResponseValid,
  input  logic [31:0] busResponseData
);

  localparam int COUNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [COUNT_WIDTH-1:0] STARVE_MAX = COUNT_WIDTH'(STARVE_LIMIT);

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_REQUEST = 2'd1;
  localparam logic [1:0] STATE_WAIT    = 2'd2;

  logic [1:0]             rState;
  logic                   rOwnerFetch;
  logic                   rDropFetch;
  logic [COUNT_WIDTH-1:0] rStarveCount;

  logic        wStarved;
  logic        wPickFetch;
  logic        wResponse;
  logic [1:0]  wLane;
  logic [3:0]  wDataEnable;
  logic [31:0] wDataWrite;

  assign wStarved   = (rStarveCount == STARVE_MAX);
  assign wPickFetch = fetchRequest && (!memoryRequest || wStarved);
  assign wLane      = memoryAddress[1:0];

  // Store data is replicated across all lanes so the enables alone pick the bytes.
  always_comb begin
    wDataEnable = 4'b1111;
    wDataWrite  = memoryWriteData;
    case (memoryWidth)
      2'b00: begin
        wDataEnable = 4'b0001 << wLane;
        wDataWrite  = {4{memoryWriteData[7:0]}};
      end
      2'b01: begin
        wDataEnable = 4'b0011 << {wLane[1], 1'b0};
        wDataWrite  = {2{memoryWriteData[15:0]}};
      end
      default: ;
    endcase
  end

  assign wResponse           = (rState == STATE_WAIT) && busResponseValid;
  assign fetchResponseValid  = wResponse && rOwnerFetch && !rDropFetch && !fetchFlush;
  assign fetchResponseData   = fetchResponseValid ? busResponseData : 32'd0;
  assign memoryResponseValid = wResponse && !rOwnerFetch;
  assign memoryResponseData  = memoryResponseValid ? busResponseData : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rState          <= STATE_IDLE;
      rOwnerFetch     <= 1'b0;
      rDropFetch      <= 1'b0;
      rStarveCount    <= '0;
      fetchGrant      <= 1'b0;
      memoryGrant     <= 1'b0;
      busRequestValid <= 1'b0;
      busAddress      <= 32'd0;
      busWriteEnable  <= 1'b0;
      busByteEnable   <= 4'd0;
      busWriteData    <= 32'd0;
    end else begin
      fetchGrant  <= 1'b0;
      memoryGrant <= 1'b0;
      case (rState)
        STATE_IDLE: begin
          if (fetchRequest || memoryRequest) begin
            rState          <= STATE_REQUEST;
            busRequestValid <= 1'b1;
            rOwnerFetch     <= wPickFetch;
            fetchGrant      <= wPickFetch;
            memoryGrant     <= !wPickFetch;
            if (wPickFetch) begin
              busAddress     <= fetchAddress & 32'hFFFF_FFFC;
              busWriteEnable <= 1'b0;
              busByteEnable  <= 4'b1111;
              busWriteData   <= 32'd0;
              rStarveCount   <= '0;
            end else begin
              busAddress     <= memoryAddress & 32'hFFFF_FFFC;
              busWriteEnable <= memoryWriteEnable;
              busByteEnable  <= wDataEnable;
              busWriteData   <= wDataWrite;
              if (!fetchRequest) begin
                rStarveCount <= '0;
              end else if (!wStarved) begin
                rStarveCount <= rStarveCount + 1'b1;
              end
            end
          end
        end
        STATE_REQUEST: begin
          if (rOwnerFetch && fetchFlush) begin
            rDropFetch <= 1'b1;
          end
          if (busRequestReady) begin
            rState          <= STATE_WAIT;
            busRequestValid <= 1'b0;
          end
        end
        STATE_WAIT: begin
          if (busResponseValid) begin
            rState     <= STATE_IDLE;
            rDropFetch <= 1'b0;
          end else if (rOwnerFetch && fetchFlush) begin
            rDropFetch <= 1'b1;
          end
        end
        default: rState <= STATE_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// tb_memory_port_arbiter: randomized transaction-level checking of memory_port_arbiter
module tb_memory_port_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchRequest, fetchFlush, fetchGrant, fetchResponseValid;
  logic [31:0] fetchAddress, fetchResponseData;
  logic        memoryRequest, memoryWriteEnable, memoryGrant, memoryResponseValid;
  logic [1:0]  memoryWidth;
  logic [31:0] memoryAddress, memoryWriteData, memoryResponseData;
  logic        busRequestValid, busRequestReady, busWriteEnable, busResponseValid;
  logic [31:0] busAddress, busWriteData, busResponseData;
  logic [3:0]  busByteEnable;

  int checkCount = 0;
  int errorCount = 0;
  int starveModel = 0;
  bit saw;

  memory_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .fetchFlush(fetchFlush),
    .fetchGrant(fetchGrant), .fetchResponseValid(fetchResponseValid),
    .fetchResponseData(fetchResponseData),
    .memoryRequest(memoryRequest), .memoryAddress(memoryAddress),
    .memoryWriteEnable(memoryWriteEnable), .memoryWidth(memoryWidth),
    .memoryWriteData(memoryWriteData), .memoryGrant(memoryGrant),
    .memoryResponseValid(memoryResponseValid), .memoryResponseData(memoryResponseData),
    .busRequestValid(busRequestValid), .busRequestReady(busRequestReady),
    .busAddress(busAddress), .busWriteEnable(busWriteEnable),
    .busByteEnable(busByteEnable), .busWriteData(busWriteData),
    .busResponseValid(busResponseValid), .busResponseData(busResponseData)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] expEnable(input logic [1:0] width, input logic [31:0] addr);
    int size;
    int off;
    size = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    off  = ((addr % 4) / size) * size;
    return 4'(((1 << size) - 1) << off);
  endfunction

  function automatic logic [31:0] expWriteData(input logic [1:0] width, input logic [31:0] data);
    if (width == 2'd0) return (data & 32'hFF) * 32'h0101_0101;
    if (width == 2'd1) return (data & 32'hFFFF) * 32'h0001_0001;
    return data;
  endfunction

  task automatic checkQuiet(input string tag, input bit withBus);
    checkValue({tag, ".fetchGrant"}, fetchGrant, 0);
    checkValue({tag, ".memoryGrant"}, memoryGrant, 0);
    checkValue({tag, ".busRequestValid"}, busRequestValid, 0);
    checkValue({tag, ".fetchResponseValid"}, fetchResponseValid, 0);
    checkValue({tag, ".memoryResponseValid"}, memoryResponseValid, 0);
    checkValue({tag, ".fetchResponseData"}, fetchResponseData, 0);
    checkValue({tag, ".memoryResponseData"}, memoryResponseData, 0);
    if (withBus) begin
      checkValue({tag, ".busAddress"}, busAddress, 0);
      checkValue({tag, ".busWriteEnable"}, busWriteEnable, 0);
      checkValue({tag, ".busByteEnable"}, busByteEnable, 0);
      checkValue({tag, ".busWriteData"}, busWriteData, 0);
    end
  endtask

  // One cycle with no requester active; stray bus activity must be ignored.
  task automatic idleCycle(input bit stray);
    busResponseValid = stray;
    busResponseData  = $urandom;
    busRequestReady  = 1'($urandom);
    fetchFlush       = 1'($urandom);
    #1;
    checkQuiet("idle", 1'b0);
    @(posedge clock); #1;
    busResponseValid = 1'b0;
    busRequestReady  = 1'b0;
    fetchFlush       = 1'b0;
  endtask

  // Runs one complete transaction starting with the DUT idle and requests on the lines.
  task automatic runTxn(input int rdyDly, input int rspDly, input int flushAt, input bit stray,
                        input logic [31:0] rsp, output bit sawFetch);
    bit ownF, drop, expF, expM;
    logic [31:0] eAddr, eData;
    logic [3:0] eBe;
    logic eWe;
    int cyc;
    ownF = fetchRequest && (!memoryRequest || starveModel == STARVE_LIMIT);
    if (ownF || !fetchRequest) starveModel = 0;
    else if (starveModel < STARVE_LIMIT) starveModel++;
    if (ownF) begin
      eAddr = fetchAddress & ~32'h3; eBe = 4'hF; eWe = 1'b0; eData = 32'd0;
    end else begin
      eAddr = memoryAddress & ~32'h3;
      eBe   = expEnable(memoryWidth, memoryAddress);
      eWe   = memoryWriteEnable;
      eData = expWriteData(memoryWidth, memoryWriteData);
    end
    busRequestReady = 1'b0; busResponseValid = 1'b0; fetchFlush = 1'b0;
    @(posedge clock); #1;
    sawFetch = fetchGrant;
    checkValue("fetchGrant", fetchGrant, ownF);
    checkValue("memoryGrant", memoryGrant, !ownF);
    if (ownF) fetchRequest = 1'b0; else memoryRequest = 1'b0;
    drop = 1'b0;
    cyc  = 1;
    for (int k = 0; k <= rdyDly; k++) begin
      fetchFlush       = (cyc == flushAt);
      busRequestReady  = (k == rdyDly);
      busResponseValid = stray;
      busResponseData  = $urandom;
      #1;
      checkValue("req.busRequestValid", busRequestValid, 1);
      checkValue("req.busAddress", busAddress, eAddr);
      checkValue("req.busByteEnable", busByteEnable, eBe);
      checkValue("req.busWriteEnable", busWriteEnable, eWe);
      checkValue("req.busWriteData", busWriteData, eData);
      checkValue("req.fetchResponseValid", fetchResponseValid, 0);
      checkValue("req.memoryResponseValid", memoryResponseValid, 0);
      if (fetchFlush && ownF) drop = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    for (int k = 0; k <= rspDly; k++) begin
      fetchFlush       = (cyc == flushAt);
      busRequestReady  = 1'($urandom);
      busResponseValid = (k == rspDly);
      busResponseData  = (k == rspDly) ? rsp : $urandom;
      #1;
      expF = ownF && busResponseValid && !drop && !fetchFlush;
      expM = !ownF && busResponseValid;
      checkValue("wait.busRequestValid", busRequestValid, 0);
      checkValue("wait.fetchGrant", fetchGrant, 0);
      checkValue("wait.memoryGrant", memoryGrant, 0);
      checkValue("wait.fetchResponseValid", fetchResponseValid, expF);
      checkValue("wait.memoryResponseValid", memoryResponseValid, expM);
      checkValue("wait.fetchResponseData", fetchResponseData, expF ? rsp : 32'd0);
      checkValue("wait.memoryResponseData", memoryResponseData, expM ? rsp : 32'd0);
      if (fetchFlush && ownF) drop = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    busResponseValid = 1'b0; busRequestReady = 1'b0; fetchFlush = 1'b0;
  endtask

  task automatic raiseRandom();
    if (!fetchRequest && $urandom_range(0, 1) == 0) begin
      fetchRequest = 1'b1;
      fetchAddress = $urandom;
    end
    if (!memoryRequest && $urandom_range(0, 1) == 0) begin
      memoryRequest     = 1'b1;
      memoryAddress     = $urandom;
      memoryWidth       = 2'($urandom);
      memoryWriteEnable = 1'($urandom);
      memoryWriteData   = $urandom;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    fetchRequest = 1'b0; fetchAddress = 32'd0; fetchFlush = 1'b0;
    memoryRequest = 1'b0; memoryAddress = 32'd0; memoryWriteEnable = 1'b0;
    memoryWidth = 2'd0; memoryWriteData = 32'd0;
    busRequestReady = 1'b0; busResponseValid = 1'b0; busResponseData = 32'd0;
    #3;
    checkQuiet("reset", 1'b1);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Lone fetch
    fetchRequest = 1'b1; fetchAddress = 32'h8000_0000;
    runTxn(0, 0, 0, 1'b0, 32'h0000_0013, saw);
    // Byte store to 0x1003
    memoryRequest = 1'b1; memoryAddress = 32'h1003; memoryWidth = 2'd0;
    memoryWriteEnable = 1'b1; memoryWriteData = 32'h0000_00AB;
    runTxn(1, 1, 0, 1'b1, $urandom, saw);
    // Half store to 0x1002
    memoryRequest = 1'b1; memoryAddress = 32'h1002; memoryWidth = 2'd1;
    memoryWriteEnable = 1'b1; memoryWriteData = 32'h0000_1234;
    runTxn(0, 0, 0, 1'b0, $urandom, saw);
    // Fetch flushed while the bus stalls, then a normal fetch
    fetchRequest = 1'b1; fetchAddress = 32'h8000_0040;
    runTxn(5, 0, 3, 1'b0, 32'hDEAD_BEEF, saw);
    fetchRequest = 1'b1; fetchAddress = 32'h8000_0044;
    runTxn(0, 2, 0, 1'b0, 32'hCAFE_F00D, saw);

    // Both requesting continuously: fetch wins every fifth grant
    fetchRequest = 1'b1; fetchAddress = 32'h8000_0100;
    for (int i = 0; i < 10; i++) begin
      if (!memoryRequest) begin
        memoryRequest = 1'b1; memoryAddress = $urandom; memoryWidth = 2'($urandom);
        memoryWriteEnable = 1'($urandom); memoryWriteData = $urandom;
      end
      if (!fetchRequest) fetchRequest = 1'b1;
      runTxn(0, 0, 0, 1'b0, $urandom, saw);
      checkValue("grantOrder", saw, (i % 5 == 4));
    end
    fetchRequest = 1'b0; memoryRequest = 1'b0;
    starveModel = 0;
    idleCycle(1'b1);

    for (int n = 0; n < 150; n++) begin
      raiseRandom();
      if (!fetchRequest && !memoryRequest) idleCycle(1'($urandom));
      else runTxn($urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                  1'($urandom), $urandom, saw);
    end
    while (fetchRequest || memoryRequest)
      runTxn(0, 0, 0, 1'b0, $urandom, saw);

    // Reset in the middle of a transaction
    memoryRequest = 1'b1; memoryAddress = 32'h2000; memoryWidth = 2'd2;
    memoryWriteEnable = 1'b1; memoryWriteData = $urandom;
    @(posedge clock); #1;
    memoryRequest = 1'b0; busRequestReady = 1'b1;
    @(posedge clock); #1;
    busRequestReady = 1'b0;
    reset = 1'b1; busResponseValid = 1'b1; busResponseData = 32'h1234_5678;
    #1;
    checkQuiet("midReset", 1'b1);
    @(posedge clock); #1;
    reset = 1'b0; busResponseValid = 1'b0;
    starveModel = 0;
    idleCycle(1'b1);
    fetchRequest = 1'b1; fetchAddress = 32'h8000_0200;
    runTxn(0, 0, 0, 1'b0, 32'h0000_0093, saw);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
`default_nettype wire
